// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM init sequencer: command codes,
// sequencer states and mode-register field helpers.
package sdram_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    typedef enum logic [3:0] {
        CMD_LMR = 4'b0000,
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b0111,
        CMD_INH = 4'b1111
    } cmd_e;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'b0000_0001,
        ST_PWRUP = 8'b0000_0010,
        ST_PRE   = 8'b0000_0100,
        ST_REF   = 8'b0000_1000,
        ST_MRS   = 8'b0001_0000,
        ST_EMRS  = 8'b0010_0000,
        ST_DONE  = 8'b0100_0000,
        ST_MR_WR = 8'b1000_0000
    } state_e;

    localparam int MR_BL_LSB = 0;
    localparam int MR_BT_BIT = 3;
    localparam int MR_CL_LSB = 4;
    localparam int MR_WB_BIT = 9;

    function automatic logic [12:0] mr_encode(
        input logic [2:0] bl,
        input logic       bt,
        input logic [2:0] cl,
        input logic       wb
    );
        logic [12:0] v;
        v = '0;
        v[MR_BL_LSB +: 3] = bl;
        v[MR_BT_BIT]      = bt;
        v[MR_CL_LSB +: 3] = cl;
        v[MR_WB_BIT]      = wb;
        return v;
    endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// Command bus plus init/MR handshake between the init sequencer
// and the controller top.
interface sdram_init_seq_if #(
    parameter int AW = 13,
    parameter int BW = 2
);
    logic          init_done;
    logic          seq_busy;
    logic          reinit_req;
    logic          mr_req;
    logic [AW-1:0] mr_data;
    logic          mr_ack;
    logic          sdram_cke;
    logic          sdram_cs_n;
    logic          sdram_ras_n;
    logic          sdram_cas_n;
    logic          sdram_we_n;
    logic [BW-1:0] sdram_ba;
    logic [AW-1:0] sdram_addr;

    modport master (
        input  reinit_req, mr_req, mr_data,
        output init_done, seq_busy, mr_ack,
        output sdram_cke, sdram_cs_n, sdram_ras_n,
        output sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
    );

    modport slave (
        output reinit_req, mr_req, mr_data,
        input  init_done, seq_busy, mr_ack,
        input  sdram_cke, sdram_cs_n, sdram_ras_n,
        input  sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
    );
endinterface

// File: rtl/sdram_cyc_timer.sv
// Loadable down-counter that stops at zero; o_zero flags expiry.
module sdram_cyc_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_en,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/sdram_init_seq.sv
// SDRAM power-up / re-init sequencer with runtime mode-register
// write handshake. Owns the command bus until init_done.
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int SDRAM_ADDR_WIDTH = 13,
    parameter int SDRAM_BA_WIDTH   = 2,
    parameter int CLK_FREQ_MHZ     = 100,
    parameter int POWERUP_US       = 200,
    parameter int tRP_CYCLE        = 2,
    parameter int tRFC_CYCLE       = 7,
    parameter int tMRD_CYCLE       = 2,
    parameter int INIT_REF_CNT     = 8,
    parameter logic [SDRAM_ADDR_WIDTH-1:0] MR_VALUE =
        SDRAM_ADDR_WIDTH'(mr_encode(3'd0, 1'b0, 3'd3, 1'b0)),
    parameter int EMR_EN           = 0,
    parameter logic [SDRAM_ADDR_WIDTH-1:0] EMR_VALUE = '0
) (
    input logic              clk,
    input logic              reset_n,
    sdram_init_seq_if.master bus
);
    localparam int PWR_CYC = POWERUP_US * CLK_FREQ_MHZ;
    localparam int T_A  = (PWR_CYC > tRFC_CYCLE) ? PWR_CYC : tRFC_CYCLE;
    localparam int T_B  = (T_A > tRP_CYCLE) ? T_A : tRP_CYCLE;
    localparam int TMAX = (T_B > tMRD_CYCLE) ? T_B : tMRD_CYCLE;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(INIT_REF_CNT + 1);

    localparam logic [TW-1:0] PWR_LD = TW'(PWR_CYC - 1);
    localparam logic [TW-1:0] RP_LD  = TW'(tRP_CYCLE - 1);
    localparam logic [TW-1:0] RFC_LD = TW'(tRFC_CYCLE - 1);
    localparam logic [TW-1:0] MRD_LD = TW'(tMRD_CYCLE - 1);
    localparam logic [RW-1:0] REF_LD = RW'(INIT_REF_CNT - 1);

    state_e                      r_state;
    state_e                      w_next;
    logic                        r_first;
    logic                        r_mr_ack;
    logic [SDRAM_ADDR_WIDTH-1:0] r_mr_data;

    logic                        w_load;
    logic [TW-1:0]               w_load_val;
    logic                        w_tzero;
    logic                        w_rload;
    logic                        w_rdec;
    logic                        w_rzero;
    logic                        w_mr_acc;
    logic                        w_ack_set;

    cmd_e                        w_cmd;
    logic                        w_cke;
    logic [SDRAM_BA_WIDTH-1:0]   w_ba;
    logic [SDRAM_ADDR_WIDTH-1:0] w_addr;
    logic                        w_init_done;
    logic                        w_busy;

    sdram_cyc_timer #(.W(TW)) u_tmr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load),
        .i_val   (w_load_val),
        .i_en    (1'b1),
        .o_zero  (w_tzero)
    );

    sdram_cyc_timer #(.W(RW)) u_ref (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_rload),
        .i_val   (REF_LD),
        .i_en    (w_rdec),
        .o_zero  (w_rzero)
    );

    // r_first marks the issue cycle of each timed step
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_first   <= 1'b0;
            r_mr_ack  <= 1'b0;
            r_mr_data <= '0;
        end else begin
            r_state  <= w_next;
            r_first  <= w_load;
            r_mr_ack <= w_ack_set;
            if (w_mr_acc) begin
                r_mr_data <= bus.mr_data;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_rload    = 1'b0;
        w_rdec     = 1'b0;
        w_mr_acc   = 1'b0;
        w_ack_set  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_next     = ST_PWRUP;
                w_load     = 1'b1;
                w_load_val = PWR_LD;
            end
            ST_PWRUP: begin
                if (w_tzero) begin
                    w_next     = ST_PRE;
                    w_load     = 1'b1;
                    w_load_val = RP_LD;
                end
            end
            ST_PRE: begin
                if (w_tzero) begin
                    w_next     = ST_REF;
                    w_load     = 1'b1;
                    w_load_val = RFC_LD;
                    w_rload    = 1'b1;
                end
            end
            ST_REF: begin
                if (w_tzero && w_rzero) begin
                    w_next     = ST_MRS;
                    w_load     = 1'b1;
                    w_load_val = MRD_LD;
                end else if (w_tzero) begin
                    w_rdec     = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = RFC_LD;
                end
            end
            ST_MRS: begin
                if (w_tzero && EMR_EN != 0) begin
                    w_next     = ST_EMRS;
                    w_load     = 1'b1;
                    w_load_val = MRD_LD;
                end else if (w_tzero) begin
                    w_next = ST_DONE;
                end
            end
            ST_EMRS: begin
                if (w_tzero) begin
                    w_next = ST_DONE;
                end
            end
            // the ack cycle blocks re-accepting the still-held mr_req
            ST_DONE: begin
                if (bus.reinit_req) begin
                    w_next     = ST_PRE;
                    w_load     = 1'b1;
                    w_load_val = RP_LD;
                end else if (bus.mr_req && !r_mr_ack) begin
                    w_next     = ST_MR_WR;
                    w_load     = 1'b1;
                    w_load_val = MRD_LD;
                    w_mr_acc   = 1'b1;
                end
            end
            ST_MR_WR: begin
                if (w_tzero) begin
                    w_next    = ST_DONE;
                    w_ack_set = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd       = CMD_NOP;
        w_cke       = 1'b1;
        w_ba        = '0;
        w_addr      = '0;
        w_init_done = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            ST_IDLE: begin
                w_cmd = CMD_INH;
                w_cke = 1'b0;
            end
            ST_PRE: begin
                if (r_first) begin
                    w_cmd      = CMD_PRE;
                    w_addr[10] = 1'b1;
                end
            end
            ST_REF: begin
                if (r_first) begin
                    w_cmd = CMD_REF;
                end
            end
            ST_MRS: begin
                if (r_first) begin
                    w_cmd  = CMD_LMR;
                    w_addr = MR_VALUE;
                end
            end
            ST_EMRS: begin
                if (r_first) begin
                    w_cmd  = CMD_LMR;
                    w_ba   = SDRAM_BA_WIDTH'(2'b10);
                    w_addr = EMR_VALUE;
                end
            end
            ST_DONE: begin
                w_init_done = 1'b1;
                w_busy      = 1'b0;
            end
            ST_MR_WR: begin
                w_init_done = 1'b1;
                if (r_first) begin
                    w_cmd  = CMD_LMR;
                    w_addr = r_mr_data;
                end
            end
            default: ;
        endcase
    end

    assign bus.init_done   = w_init_done;
    assign bus.seq_busy    = w_busy;
    assign bus.mr_ack      = r_mr_ack;
    assign bus.sdram_cke   = w_cke;
    assign bus.sdram_cs_n  = w_cmd[3];
    assign bus.sdram_ras_n = w_cmd[2];
    assign bus.sdram_cas_n = w_cmd[1];
    assign bus.sdram_we_n  = w_cmd[0];
    assign bus.sdram_ba    = w_ba;
    assign bus.sdram_addr  = w_addr;
endmodule

// File: tb/tb_sdram_init_seq.sv
// Scoreboard bench for sdram_init_seq: expected command/status events
// are queued per scenario and matched against the bus as they appear.
module tb_sdram_init_seq;
    localparam int TRP  = 2;
    localparam int TRFC = 7;
    localparam int TMRD = 2;
    localparam int NREF = 2;
    localparam int PWR  = 200;
    localparam logic [12:0] MRV  = 13'h030;
    localparam logic [12:0] EMRV = 13'h004;
    localparam logic [3:0] C_LMR = 4'b0000;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_INH = 4'b1111;

    typedef struct packed {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        done;
        logic        ack;
    } ev_t;

    logic clk = 1'b0;
    logic rst0_n = 1'b0;
    logic rst1_n = 1'b0;
    int   cyc0 = 0;
    int   cyc1 = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  q0[$];
    ev_t  q1[$];
    ev_t  o0, e0, o1, e1;
    logic p0 = 1'b0;
    logic p1 = 1'b0;

    always #5 clk = ~clk;

    sdram_init_seq_if #(.AW(13), .BW(2)) bus0 ();
    sdram_init_seq_if #(.AW(13), .BW(2)) bus1 ();

    sdram_init_seq #(
        .SDRAM_ADDR_WIDTH (13),
        .SDRAM_BA_WIDTH   (2),
        .CLK_FREQ_MHZ     (1),
        .POWERUP_US       (200),
        .tRP_CYCLE        (2),
        .tRFC_CYCLE       (7),
        .tMRD_CYCLE       (2),
        .INIT_REF_CNT     (2),
        .EMR_EN           (0)
    ) dut0 (
        .clk     (clk),
        .reset_n (rst0_n),
        .bus     (bus0)
    );

    sdram_init_seq #(
        .SDRAM_ADDR_WIDTH (13),
        .SDRAM_BA_WIDTH   (2),
        .CLK_FREQ_MHZ     (1),
        .POWERUP_US       (200),
        .tRP_CYCLE        (2),
        .tRFC_CYCLE       (7),
        .tMRD_CYCLE       (2),
        .INIT_REF_CNT     (2),
        .MR_VALUE         (MRV),
        .EMR_EN           (1),
        .EMR_VALUE        (EMRV)
    ) dut1 (
        .clk     (clk),
        .reset_n (rst1_n),
        .bus     (bus1)
    );

    always @(posedge clk) cyc0 <= rst0_n ? cyc0 + 1 : 0;
    always @(posedge clk) cyc1 <= rst1_n ? cyc1 + 1 : 0;

    function automatic ev_t mk(input int c, input logic [3:0] cmd,
                               input logic [1:0] ba, input logic [12:0] a,
                               input logic d, input logic k);
        ev_t e;
        e.cyc  = c;
        e.cmd  = cmd;
        e.ba   = ba;
        e.addr = a;
        e.done = d;
        e.ack  = k;
        return e;
    endfunction

    task automatic push(input int sel, input ev_t e);
        if (sel == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Init events from the PRE cycle p onward
    task automatic push_seq(input int sel, input int p);
        int t;
        t = p;
        push(sel, mk(t, C_PRE, 2'd0, 13'h400, 1'b0, 1'b0));
        t += TRP;
        for (int i = 0; i < NREF; i++) begin
            push(sel, mk(t, C_REF, 2'd0, 13'h0, 1'b0, 1'b0));
            t += TRFC;
        end
        push(sel, mk(t, C_LMR, 2'd0, MRV, 1'b0, 1'b0));
        t += TMRD;
        if (sel != 0) begin
            push(sel, mk(t, C_LMR, 2'b10, EMRV, 1'b0, 1'b0));
            t += TMRD;
        end
        push(sel, mk(t, C_NOP, 2'd0, 13'h0, 1'b1, 1'b0));
    endtask

    always @(negedge clk) begin
        if (!rst0_n) begin
            p0 = 1'b0;
        end else begin
            o0 = mk(cyc0, {bus0.sdram_cs_n, bus0.sdram_ras_n, bus0.sdram_cas_n,
                    bus0.sdram_we_n}, bus0.sdram_ba, bus0.sdram_addr,
                    bus0.init_done, bus0.mr_ack);
            if ((o0.cmd != C_NOP && o0.cmd != C_INH) || o0.done != p0 || o0.ack) begin
                total++;
                if (q0.size() == 0) begin
                    bad++;
                    $display("FAIL sb0_extra got cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b want none",
                             o0.cyc, o0.cmd, o0.ba, o0.addr, o0.done, o0.ack);
                end else begin
                    e0 = q0.pop_front();
                    if (o0 !== e0) begin
                        bad++;
                        $display("FAIL sb0 got cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b want cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b",
                                 o0.cyc, o0.cmd, o0.ba, o0.addr, o0.done, o0.ack,
                                 e0.cyc, e0.cmd, e0.ba, e0.addr, e0.done, e0.ack);
                    end
                end
            end
            p0 = o0.done;
        end
    end

    always @(negedge clk) begin
        if (!rst1_n) begin
            p1 = 1'b0;
        end else begin
            o1 = mk(cyc1, {bus1.sdram_cs_n, bus1.sdram_ras_n, bus1.sdram_cas_n,
                    bus1.sdram_we_n}, bus1.sdram_ba, bus1.sdram_addr,
                    bus1.init_done, bus1.mr_ack);
            if ((o1.cmd != C_NOP && o1.cmd != C_INH) || o1.done != p1 || o1.ack) begin
                total++;
                if (q1.size() == 0) begin
                    bad++;
                    $display("FAIL sb1_extra got cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b want none",
                             o1.cyc, o1.cmd, o1.ba, o1.addr, o1.done, o1.ack);
                end else begin
                    e1 = q1.pop_front();
                    if (o1 !== e1) begin
                        bad++;
                        $display("FAIL sb1 got cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b want cyc=%0d cmd=%b ba=%b addr=%h done=%b ack=%b",
                                 o1.cyc, o1.cmd, o1.ba, o1.addr, o1.done, o1.ack,
                                 e1.cyc, e1.cmd, e1.ba, e1.addr, e1.done, e1.ack);
                    end
                end
            end
            p1 = o1.done;
        end
    end

    task automatic test_reset();
        logic [3:0] c;
        rst0_n = 1'b0;
        rst1_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        c = {bus0.sdram_cs_n, bus0.sdram_ras_n, bus0.sdram_cas_n, bus0.sdram_we_n};
        total++;
        if (c !== C_INH) begin bad++; $display("FAIL rst_cmd got=%b want=%b", c, C_INH); end
        total++;
        if (bus0.sdram_cke !== 1'b0) begin bad++; $display("FAIL rst_cke got=%b want=0", bus0.sdram_cke); end
        total++;
        if (bus0.init_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", bus0.init_done); end
        total++;
        if (bus0.seq_busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", bus0.seq_busy); end
        total++;
        if (bus0.mr_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", bus0.mr_ack); end
        total++;
        if (bus0.sdram_addr !== 13'h0 || bus0.sdram_ba !== 2'd0) begin
            bad++;
            $display("FAIL rst_addr got addr=%h ba=%b want 0", bus0.sdram_addr, bus0.sdram_ba);
        end
        push_seq(0, PWR + 1);
        @(posedge clk);
        #1 rst0_n = 1'b1;
        @(negedge clk);
        c = {bus0.sdram_cs_n, bus0.sdram_ras_n, bus0.sdram_cas_n, bus0.sdram_we_n};
        total++;
        if (c !== C_INH || bus0.sdram_cke !== 1'b0) begin
            bad++;
            $display("FAIL cyc0 got cmd=%b cke=%b want cmd=%b cke=0", c, bus0.sdram_cke, C_INH);
        end
        @(negedge clk);
        c = {bus0.sdram_cs_n, bus0.sdram_ras_n, bus0.sdram_cas_n, bus0.sdram_we_n};
        total++;
        if (c !== C_NOP || bus0.sdram_cke !== 1'b1) begin
            bad++;
            $display("FAIL cyc1 got cmd=%b cke=%b want cmd=%b cke=1", c, bus0.sdram_cke, C_NOP);
        end
        for (int k = 0; k < 300 && q0.size() != 0; k++) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL init_timeout pending=%0d want 0", q0.size());
            q0.delete();
        end
        @(negedge clk);
        total++;
        if (bus0.init_done !== 1'b1 || bus0.seq_busy !== 1'b0 || bus0.sdram_cke !== 1'b1) begin
            bad++;
            $display("FAIL done_state got done=%b busy=%b cke=%b want 1/0/1",
                     bus0.init_done, bus0.seq_busy, bus0.sdram_cke);
        end
    endtask

    task automatic test_mr();
        int  n;
        bit  got;
        @(posedge clk);
        #1;
        n = cyc0;
        bus0.mr_req  = 1'b1;
        bus0.mr_data = 13'h020;
        push(0, mk(n + 1, C_LMR, 2'd0, 13'h020, 1'b1, 1'b0));
        push(0, mk(n + 3, C_NOP, 2'd0, 13'h0, 1'b1, 1'b1));
        @(posedge clk);
        #1 bus0.mr_data = 13'h1FF;
        @(negedge clk);
        total++;
        if (bus0.seq_busy !== 1'b1 || bus0.init_done !== 1'b1) begin
            bad++;
            $display("FAIL mr_busy got busy=%b done=%b want 1/1", bus0.seq_busy, bus0.init_done);
        end
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus0.mr_ack) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL mr_ack_timeout got=0 want=1"); end
        @(posedge clk);
        #1 bus0.mr_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.mr_ack !== 1'b0 || bus0.seq_busy !== 1'b0) begin
            bad++;
            $display("FAIL mr_after got ack=%b busy=%b want 0/0", bus0.mr_ack, bus0.seq_busy);
        end
        repeat (4) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL mr_pending got=%0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_back_to_back();
        int  n;
        bit  got;
        @(posedge clk);
        #1;
        n = cyc0;
        bus0.mr_req  = 1'b1;
        bus0.mr_data = 13'h021;
        push(0, mk(n + 1, C_LMR, 2'd0, 13'h021, 1'b1, 1'b0));
        push(0, mk(n + 3, C_NOP, 2'd0, 13'h0, 1'b1, 1'b1));
        push(0, mk(n + 5, C_LMR, 2'd0, 13'h022, 1'b1, 1'b0));
        push(0, mk(n + 7, C_NOP, 2'd0, 13'h0, 1'b1, 1'b1));
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus0.mr_ack) got = 1'b1;
        end
        @(posedge clk);
        #1 bus0.mr_data = 13'h022;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus0.mr_ack) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL b2b_ack_timeout got=0 want=1"); end
        @(posedge clk);
        #1 bus0.mr_req = 1'b0;
        repeat (4) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL b2b_pending got=%0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_reinit();
        int n;
        @(posedge clk);
        #1;
        n = cyc0;
        bus0.reinit_req = 1'b1;
        push_seq(0, n + 1);
        @(posedge clk);
        #1 bus0.reinit_req = 1'b0;
        @(negedge clk);
        total++;
        if (bus0.init_done !== 1'b0 || bus0.seq_busy !== 1'b1) begin
            bad++;
            $display("FAIL reinit_state got done=%b busy=%b want 0/1", bus0.init_done, bus0.seq_busy);
        end
        for (int k = 0; k < 40 && q0.size() != 0; k++) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL reinit_timeout pending=%0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_both();
        int n;
        bit got;
        @(posedge clk);
        #1;
        n = cyc0;
        bus0.reinit_req = 1'b1;
        bus0.mr_req     = 1'b1;
        bus0.mr_data    = 13'h020;
        push_seq(0, n + 1);
        push(0, mk(n + 20, C_LMR, 2'd0, 13'h020, 1'b1, 1'b0));
        push(0, mk(n + 22, C_NOP, 2'd0, 13'h0, 1'b1, 1'b1));
        @(posedge clk);
        #1 bus0.reinit_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (bus0.mr_ack) got = 1'b1;
        end
        total++;
        if (!got) begin bad++; $display("FAIL both_ack_timeout got=0 want=1"); end
        @(posedge clk);
        #1 bus0.mr_req = 1'b0;
        repeat (4) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL both_pending got=%0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] c;
        @(posedge clk);
        #1 rst0_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus0.init_done !== 1'b0 || bus0.sdram_cke !== 1'b0) begin
            bad++;
            $display("FAIL rst2_state got done=%b cke=%b want 0/0", bus0.init_done, bus0.sdram_cke);
        end
        push(0, mk(PWR + 1, C_PRE, 2'd0, 13'h400, 1'b0, 1'b0));
        push(0, mk(PWR + 1 + TRP, C_REF, 2'd0, 13'h0, 1'b0, 1'b0));
        @(posedge clk);
        #1 rst0_n = 1'b1;
        for (int k = 0; k < 300 && cyc0 != 205; k++) begin
            @(posedge clk);
            #1;
        end
        rst0_n = 1'b0;
        @(posedge clk);
        #1 rst0_n = 1'b1;
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL mid_partial pending=%0d want 0", q0.size());
            q0.delete();
        end
        push_seq(0, PWR + 1);
        @(negedge clk);
        c = {bus0.sdram_cs_n, bus0.sdram_ras_n, bus0.sdram_cas_n, bus0.sdram_we_n};
        total++;
        if (c !== C_INH || bus0.sdram_cke !== 1'b0 || bus0.init_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_cyc0 got cmd=%b cke=%b done=%b want %b/0/0",
                     c, bus0.sdram_cke, bus0.init_done, C_INH);
        end
        for (int k = 0; k < 300 && q0.size() != 0; k++) @(posedge clk);
        total++;
        if (q0.size() != 0) begin
            bad++;
            $display("FAIL mid_timeout pending=%0d want 0", q0.size());
            q0.delete();
        end
    endtask

    task automatic test_emr();
        push_seq(1, PWR + 1);
        @(posedge clk);
        #1 rst1_n = 1'b1;
        for (int k = 0; k < 300 && q1.size() != 0; k++) @(posedge clk);
        total++;
        if (q1.size() != 0) begin
            bad++;
            $display("FAIL emr_timeout pending=%0d want 0", q1.size());
            q1.delete();
        end
        @(negedge clk);
        total++;
        if (bus1.init_done !== 1'b1 || bus1.seq_busy !== 1'b0) begin
            bad++;
            $display("FAIL emr_done got done=%b busy=%b want 1/0", bus1.init_done, bus1.seq_busy);
        end
    endtask

    initial begin
        bus0.reinit_req = 1'b0;
        bus0.mr_req     = 1'b0;
        bus0.mr_data    = 13'h0;
        bus1.reinit_req = 1'b0;
        bus1.mr_req     = 1'b0;
        bus1.mr_data    = 13'h0;
        test_reset();
        test_mr();
        test_back_to_back();
        test_reinit();
        test_both();
        test_reset_mid();
        test_emr();
        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
